regfile_wb_arbiter: RTL and testbench
=====================================

// Module: regfile_wb_arbiter
// PURPOSE
//   Shares the single register-file write port between two writeback sources:
//   ALU results and memory/load results. Each source gets a small FIFO with a
//   valid/ready handshake; a round-robin arbiter drains one entry per cycle onto
//   rd/write_data/write_enable. It also exports a pending-write mask so issue
//   logic can stall on RAW and WAW hazards.
// PARAMETERS
//   N      32  data width; must match the register-file data width
//   DEPTH  2   entries per source FIFO; power of two, >= 2
// PORTS
//   clk              in   1      single clock, rising edge
//   rst              in   1      reset: asynchronous, active-high
//   alu_valid        in   1      ALU writeback request
//   alu_ready        out  1      ALU FIFO can accept
//   alu_rd           in   5      ALU destination register
//   alu_data         in   N      ALU result
//   mem_valid        in   1      memory writeback request
//   mem_ready        out  1      memory FIFO can accept
//   mem_rd           in   5      memory destination register
//   mem_data         in   N      load result
//   rf_rd            out  5      to register-file rd
//   rf_write_data    out  N      to register-file write_data
//   rf_write_enable  out  1      to register-file write_enable
//   pending_mask     out  32     bit i = a queued write to x[i] exists
//   conflict_count   out  32     only with ARB_PERF_CNT_EN
// BEHAVIOUR
//   - Reset (async): both FIFOs empty, pointers 0, last_grant = MEM.
//     Outputs during and after reset: rf_write_enable=0, rf_rd=0, rf_write_data=0,
//     pending_mask=0, conflict_count=0.
//     alu_ready/mem_ready are 0 while rst=1 and 1 once rst drops.
//   - Accept: a transfer occurs when valid && ready at a clk edge. ready = !full && !rst.
//     ready does not look ahead at a same-cycle dequeue: a full FIFO stalls one cycle.
//   - rd==0 requests are accepted (handshake completes) but never enqueued.
//   - Grant (combinational from FIFO heads only):
//     - one FIFO non-empty: that FIFO wins;
//     - both non-empty: the source not equal to last_grant wins;
//     - none: rf_write_enable=0, rf_rd=0, rf_write_data=0.
//     The granted head drives rf_rd/rf_write_data with rf_write_enable=1.
//     It pops at the clk edge and last_grant is updated.
//   - Latency: accepted at edge t -> rf_write_enable=1 in cycle t+1 if uncontested.
//     Worst case under contention is DEPTH*2 cycles.
//   - Simultaneous push and pop on the same FIFO: both take effect; count unchanged.
//   - pending_mask: OR over all valid entries of both FIFOs of (1<<rd).
//     It excludes same-cycle inputs; bit 0 is always 0.
//   - Ordering: FIFO order within a source; no ordering between sources.
//     Issue logic must not issue a write to a register whose pending_mask bit is set.
//   - Pointer wrap: pointers are log2(DEPTH)+1 bits.
//     full = MSBs differ and low bits equal; empty = pointers equal.
//   - Reset mid-operation: queued writes are discarded. No partial write reaches the port.
// CONFIGURATION
//   - ARB_PERF_CNT_EN defined: conflict_count port exists. It is a 32-bit counter,
//     +1 on every cycle both FIFOs are non-empty, saturating at 32'hFFFF_FFFF,
//     cleared by rst.
//   - ARB_PERF_CNT_EN undefined: port and counter are absent; all other behaviour
//     is identical.
// STRUCTURE
//   - Shared header Rf_defs.vh:
//     - REG_ADDR_W=5, NUM_REGS=32;
//     - source encodings SRC_ALU=1'b0, SRC_MEM=1'b1 (used for last_grant).
//   - Sub-module wb_fifo (params N, DEPTH): entries {rd, data}.
//     - Outputs: full, empty, head, per-entry valid+rd vector for pending_mask.
//     - One instance per source.
//   - Top level holds the arbiter, last_grant flop, mask OR-tree and optional counter.
// TESTING
//   1. Reset: assert rst mid-queue with 2 ALU entries pending.
//      -> rf_write_enable=0, pending_mask=0, readys=0 immediately; readys=1 after release.
//   2. Single ALU write (rd=5, data=32'hDEAD_BEEF).
//      -> next cycle rf_write_enable=1, rf_rd=5, rf_write_data=DEADBEEF;
//         pending_mask[5]=1 for exactly that cycle.
//   3. ALU rd=3 and MEM rd=4 accepted on the same edge.
//      -> cycle+1 writes x3 (ALU first after reset), cycle+2 writes x4.
//   4. Continuous traffic on both sources for 8 cycles.
//      -> grants strictly alternate ALU/MEM; 8 writes total; no data loss.
//   5. Fill MEM FIFO with DEPTH entries while ALU is continuously busy.
//      -> mem_ready=0 while full; pushes resume the cycle after a MEM pop.
//   6. alu_rd=0 with alu_valid=1.
//      -> handshake completes; no rf_write_enable pulse; pending_mask stays 0.
//      With ARB_PERF_CNT_EN, test 4 yields conflict_count=7.

Source files
------------

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared definitions for the register-file writeback arbiter: register addressing,
// source encodings used for the round-robin last_grant, and a one-hot helper.
package regfile_wb_arbiter_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned NUM_REGS   = 32;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_MEM = 1'b1
  } src_e;

  // One-hot register bit; x0 never produces a pending bit.
  function automatic logic [NUM_REGS-1:0] reg_bit(input logic [REG_ADDR_W-1:0] rd);
    return (rd == '0) ? '0 : (NUM_REGS'(1) << rd);
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_wb_fifo.sv
// Per-source writeback FIFO holding {rd, data}; exposes head, full/empty and a
// per-entry valid+rd view so the top level can build the pending-write mask.
module regfile_wb_arbiter_wb_fifo
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int unsigned N     = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  logic [REG_ADDR_W-1:0]         push_rd,
  input  logic [N-1:0]                  push_data,
  input  logic                          pop,
  output logic                          full,
  output logic                          empty,
  output logic [REG_ADDR_W-1:0]         head_rd,
  output logic [N-1:0]                  head_data,
  output logic [DEPTH-1:0]              entry_valid,
  output logic [DEPTH*REG_ADDR_W-1:0]   entry_rd
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         count;
  logic [REG_ADDR_W-1:0] rd_mem   [DEPTH];
  logic [N-1:0]          data_mem [DEPTH];

  // Extra pointer MSB distinguishes full from empty when the low bits match.
  assign full  = (wr_ptr[PW-1] != rd_ptr[PW-1]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  assign count = wr_ptr - rd_ptr;

  assign head_rd   = rd_mem[rd_ptr[AW-1:0]];
  assign head_data = data_mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop && !empty) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end

  // Payload storage needs no reset: validity comes from the pointers.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      rd_mem[wr_ptr[AW-1:0]]   <= push_rd;
      data_mem[wr_ptr[AW-1:0]] <= push_data;
    end
  end

  // A slot is live when its distance from the read pointer is below the count.
  always_comb begin
    entry_valid = '0;
    entry_rd    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      logic [AW-1:0] offset;
      offset                                   = AW'(i) - rd_ptr[AW-1:0];
      entry_valid[i]                           = (PW'(offset) < count);
      entry_rd[i*REG_ADDR_W +: REG_ADDR_W]     = rd_mem[i];
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port between ALU and load
// writebacks. Define ARB_PERF_CNT_EN to add the conflict_count performance counter.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int unsigned N     = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [REG_ADDR_W-1:0] alu_rd,
  input  logic [N-1:0]          alu_data,
  input  logic                  mem_valid,
  output logic                  mem_ready,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic [N-1:0]          mem_data,
  output logic [REG_ADDR_W-1:0] rf_rd,
  output logic [N-1:0]          rf_write_data,
  output logic                  rf_write_enable,
`ifdef ARB_PERF_CNT_EN
  output logic [31:0]           conflict_count,
`endif
  output logic [NUM_REGS-1:0]   pending_mask
);

  logic                        alu_full;
  logic                        alu_empty;
  logic [REG_ADDR_W-1:0]       alu_head_rd;
  logic [N-1:0]                alu_head_data;
  logic [DEPTH-1:0]            alu_entry_valid;
  logic [DEPTH*REG_ADDR_W-1:0] alu_entry_rd;

  logic                        mem_full;
  logic                        mem_empty;
  logic [REG_ADDR_W-1:0]       mem_head_rd;
  logic [N-1:0]                mem_head_data;
  logic [DEPTH-1:0]            mem_entry_valid;
  logic [DEPTH*REG_ADDR_W-1:0] mem_entry_rd;

  logic alu_push;
  logic mem_push;
  logic grant_alu;
  logic grant_mem;
  src_e last_grant;

  // Ready ignores a same-cycle pop; writes to x0 complete the handshake but are dropped.
  assign alu_ready = !alu_full && !rst;
  assign mem_ready = !mem_full && !rst;
  assign alu_push  = alu_valid && alu_ready && (alu_rd != '0);
  assign mem_push  = mem_valid && mem_ready && (mem_rd != '0);

  regfile_wb_arbiter_wb_fifo #(
    .N     (N),
    .DEPTH (DEPTH)
  ) u_alu_fifo (
    .clk         (clk),
    .rst         (rst),
    .push        (alu_push),
    .push_rd     (alu_rd),
    .push_data   (alu_data),
    .pop         (grant_alu),
    .full        (alu_full),
    .empty       (alu_empty),
    .head_rd     (alu_head_rd),
    .head_data   (alu_head_data),
    .entry_valid (alu_entry_valid),
    .entry_rd    (alu_entry_rd)
  );

  regfile_wb_arbiter_wb_fifo #(
    .N     (N),
    .DEPTH (DEPTH)
  ) u_mem_fifo (
    .clk         (clk),
    .rst         (rst),
    .push        (mem_push),
    .push_rd     (mem_rd),
    .push_data   (mem_data),
    .pop         (grant_mem),
    .full        (mem_full),
    .empty       (mem_empty),
    .head_rd     (mem_head_rd),
    .head_data   (mem_head_data),
    .entry_valid (mem_entry_valid),
    .entry_rd    (mem_entry_rd)
  );

  // Under contention the source that did not win last time goes next.
  assign grant_alu = !alu_empty && (mem_empty || (last_grant == SRC_MEM));
  assign grant_mem = !mem_empty && (alu_empty || (last_grant == SRC_ALU));

  always_comb begin
    rf_write_enable = 1'b0;
    rf_rd           = '0;
    rf_write_data   = '0;
    if (grant_alu) begin
      rf_write_enable = 1'b1;
      rf_rd           = alu_head_rd;
      rf_write_data   = alu_head_data;
    end else if (grant_mem) begin
      rf_write_enable = 1'b1;
      rf_rd           = mem_head_rd;
      rf_write_data   = mem_head_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= SRC_MEM;
    end else if (grant_alu) begin
      last_grant <= SRC_ALU;
    end else if (grant_mem) begin
      last_grant <= SRC_MEM;
    end
  end

  // Pending-write mask covers queued entries only, never the current inputs.
  always_comb begin
    pending_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (alu_entry_valid[i]) begin
        pending_mask = pending_mask | reg_bit(alu_entry_rd[i*REG_ADDR_W +: REG_ADDR_W]);
      end
      if (mem_entry_valid[i]) begin
        pending_mask = pending_mask | reg_bit(mem_entry_rd[i*REG_ADDR_W +: REG_ADDR_W]);
      end
    end
  end

`ifdef ARB_PERF_CNT_EN
  logic both_pending;

  assign both_pending = !alu_empty && !mem_empty;

  // Saturating count of cycles where both sources compete for the port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      conflict_count <= '0;
    end else if (both_pending && (conflict_count != 32'hFFFF_FFFF)) begin
      conflict_count <= conflict_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: drivers feed per-source stimulus
// queues, a negedge monitor compares every output against a reference queue model.
module tb_regfile_wb_arbiter;

  localparam int unsigned N     = 32;
  localparam int unsigned DEPTH = 2;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } item_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        alu_valid = 1'b0;
  logic        alu_ready;
  logic [4:0]  alu_rd = '0;
  logic [31:0] alu_data = '0;
  logic        mem_valid = 1'b0;
  logic        mem_ready;
  logic [4:0]  mem_rd = '0;
  logic [31:0] mem_data = '0;
  logic [4:0]  rf_rd;
  logic [31:0] rf_write_data;
  logic        rf_write_enable;
  logic [31:0] pending_mask;
`ifdef ARB_PERF_CNT_EN
  logic [31:0] conflict_count;
`endif

  item_t alu_stim[$];
  item_t mem_stim[$];
  item_t alu_exp[$];
  item_t mem_exp[$];
  logic [4:0] wlog[$];

  int    total = 0;
  int    bad = 0;
  bit    last_src = 1'b1;
  bit    alu_took = 1'b0;
  bit    mem_took = 1'b0;
  int    mem_stalls = 0;
  int    zero_acc = 0;
  longint conf_exp = 0;

  regfile_wb_arbiter #(
    .N     (N),
    .DEPTH (DEPTH)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .alu_valid       (alu_valid),
    .alu_ready       (alu_ready),
    .alu_rd          (alu_rd),
    .alu_data        (alu_data),
    .mem_valid       (mem_valid),
    .mem_ready       (mem_ready),
    .mem_rd          (mem_rd),
    .mem_data        (mem_data),
    .rf_rd           (rf_rd),
    .rf_write_data   (rf_write_data),
    .rf_write_enable (rf_write_enable),
`ifdef ARB_PERF_CNT_EN
    .conflict_count  (conflict_count),
`endif
    .pending_mask    (pending_mask)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drivers: retire the item accepted at the last edge, then present the next one.
  always @(posedge clk) begin
    #1;
    if (alu_took && alu_stim.size() > 0) alu_stim.delete(0);
    if (mem_took && mem_stim.size() > 0) mem_stim.delete(0);
    alu_took = 1'b0;
    mem_took = 1'b0;
    if (alu_stim.size() > 0) begin
      alu_valid = 1'b1;
      alu_rd    = alu_stim[0].rd;
      alu_data  = alu_stim[0].data;
    end else begin
      alu_valid = 1'b0;
    end
    if (mem_stim.size() > 0) begin
      mem_valid = 1'b1;
      mem_rd    = mem_stim[0].rd;
      mem_data  = mem_stim[0].data;
    end else begin
      mem_valid = 1'b0;
    end
  end

  // Monitor: reference model of queued writes, grant order and handshakes.
  always @(negedge clk) begin
    logic [31:0] m;
    item_t       it;
    bit          g_alu;
    bit          g_mem;
    bit          both;
    if (rst) begin
      alu_exp.delete();
      mem_exp.delete();
      last_src = 1'b1;
      conf_exp = 0;
    end
    m = '0;
    foreach (alu_exp[i]) m[alu_exp[i].rd] = 1'b1;
    foreach (mem_exp[i]) m[mem_exp[i].rd] = 1'b1;
    chk("pending_mask", 64'(pending_mask), 64'(m));
    chk("alu_ready", 64'(alu_ready), 64'(!rst && alu_exp.size() < DEPTH));
    chk("mem_ready", 64'(mem_ready), 64'(!rst && mem_exp.size() < DEPTH));
`ifdef ARB_PERF_CNT_EN
    chk("conflict_count", 64'(conflict_count), 64'(conf_exp));
`endif
    both  = (alu_exp.size() > 0) && (mem_exp.size() > 0);
    g_alu = (alu_exp.size() > 0) && ((mem_exp.size() == 0) || last_src);
    g_mem = (mem_exp.size() > 0) && !g_alu;
    if (g_alu || g_mem) begin
      it       = g_alu ? alu_exp.pop_front() : mem_exp.pop_front();
      last_src = g_mem;
      chk("rf_write_enable", 64'(rf_write_enable), 64'd1);
      chk("rf_rd", 64'(rf_rd), 64'(it.rd));
      chk("rf_write_data", 64'(rf_write_data), 64'(it.data));
      wlog.push_back(rf_rd);
    end else begin
      chk("idle_we", 64'(rf_write_enable), 64'd0);
      chk("idle_rd_data", {27'd0, rf_rd, rf_write_data}, 64'd0);
    end
    if (both) conf_exp++;
    alu_took = alu_valid && alu_ready;
    mem_took = mem_valid && mem_ready;
    if (alu_took && alu_rd != 5'd0) alu_exp.push_back('{alu_rd, alu_data});
    if (mem_took && mem_rd != 5'd0) mem_exp.push_back('{mem_rd, mem_data});
    if (alu_took && alu_rd == 5'd0) zero_acc++;
    if (mem_valid && !mem_ready && !rst) mem_stalls++;
  end

  task automatic wait_idle(input string name);
    bit done = 1'b0;
    for (int c = 0; c < 300 && !done; c++) begin
      @(posedge clk);
      if (alu_stim.size() == 0 && mem_stim.size() == 0 && alu_exp.size() == 0 &&
          mem_exp.size() == 0 && !alu_valid && !mem_valid) done = 1'b1;
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL %s: timeout, traffic did not drain", name);
    end
    repeat (2) @(posedge clk);
    #2;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #2;

    // Both sources on one edge right after reset: ALU wins first.
    wlog.delete();
    alu_stim.push_back('{5'd3, 32'h0000_0333});
    mem_stim.push_back('{5'd4, 32'h0000_0444});
    wait_idle("t3");
    chk("t3_writes", 64'(wlog.size()), 64'd2);
    if (wlog.size() == 2) begin
      chk("t3_first_x3", 64'(wlog[0]), 64'd3);
      chk("t3_second_x4", 64'(wlog[1]), 64'd4);
    end

    // Single ALU write.
    wlog.delete();
    alu_stim.push_back('{5'd5, 32'hDEAD_BEEF});
    wait_idle("t2");
    chk("t2_writes", 64'(wlog.size()), 64'd1);
    if (wlog.size() == 1) chk("t2_rd", 64'(wlog[0]), 64'd5);

    // Continuous traffic on both sources: last grant was ALU, so MEM leads.
    begin
`ifdef ARB_PERF_CNT_EN
      longint c0;
      c0 = conf_exp;
`endif
      wlog.delete();
      alu_stim.push_back('{5'd1, 32'hA000_0001});
      alu_stim.push_back('{5'd2, 32'hA000_0002});
      alu_stim.push_back('{5'd6, 32'hA000_0006});
      alu_stim.push_back('{5'd7, 32'hA000_0007});
      mem_stim.push_back('{5'd8, 32'hB000_0008});
      mem_stim.push_back('{5'd9, 32'hB000_0009});
      mem_stim.push_back('{5'd10, 32'hB000_000A});
      mem_stim.push_back('{5'd11, 32'hB000_000B});
      wait_idle("t4");
      chk("t4_writes", 64'(wlog.size()), 64'd8);
      if (wlog.size() == 8) begin
        for (int k = 0; k < 8; k++) chk("t4_alternate", 64'(wlog[k] >= 5'd8), 64'(k % 2 == 0));
      end
`ifdef ARB_PERF_CNT_EN
      chk("t4_conflicts", 64'(longint'(conflict_count) - c0), 64'd7);
`endif
    end

    // Fill MEM while ALU stays busy: MEM must see back-pressure.
    wlog.delete();
    mem_stalls = 0;
    for (int k = 0; k < 6; k++) alu_stim.push_back('{5'(12 + k), 32'hC000_0000 + 32'(k)});
    for (int k = 0; k < 4; k++) mem_stim.push_back('{5'(18 + k), 32'hD000_0000 + 32'(k)});
    wait_idle("t5");
    chk("t5_writes", 64'(wlog.size()), 64'd10);
    chk("t5_mem_stalled", 64'(mem_stalls > 0), 64'd1);

    // Write to x0: handshake completes, nothing reaches the port.
    wlog.delete();
    zero_acc = 0;
    alu_stim.push_back('{5'd0, 32'h1234_5678});
    wait_idle("t6");
    chk("t6_handshake", 64'(zero_acc), 64'd1);
    chk("t6_no_write", 64'(wlog.size()), 64'd0);
    chk("t6_mask", 64'(pending_mask), 64'd0);

    // Reset with writes queued: everything discarded immediately.
    for (int k = 0; k < 4; k++) alu_stim.push_back('{5'(22 + k), 32'hE000_0000 + 32'(k)});
    for (int k = 0; k < 4; k++) mem_stim.push_back('{5'(26 + k), 32'hF000_0000 + 32'(k)});
    repeat (2) @(posedge clk);
    #2;
    chk("t1_pending_before", 64'(pending_mask != 32'd0), 64'd1);
    rst = 1'b1;
    alu_stim.delete();
    mem_stim.delete();
    #1;
    chk("t1_we_in_reset", 64'(rf_write_enable), 64'd0);
    chk("t1_mask_in_reset", 64'(pending_mask), 64'd0);
    chk("t1_readys_in_reset", {62'd0, alu_ready, mem_ready}, 64'd0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("t1_readys_after", {62'd0, alu_ready, mem_ready}, 64'd3);

    // After reset ALU again has priority.
    @(posedge clk);
    #2;
    wlog.delete();
    alu_stim.push_back('{5'd9, 32'h0000_0099});
    mem_stim.push_back('{5'd10, 32'h0000_00AA});
    wait_idle("post_reset");
    chk("post_reset_writes", 64'(wlog.size()), 64'd2);
    if (wlog.size() == 2) chk("post_reset_alu_first", 64'(wlog[0]), 64'd9);

    chk("final_drained", 64'(alu_exp.size() + mem_exp.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
